// File: rtl/pic_pkg.sv
package pic_pkg;

  localparam int unsigned PC_W  = 13;
  localparam int unsigned TGT_W = 11;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SP_W  = 3;

  localparam logic [PC_W-1:0] RESET_VECTOR = '0;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ret_stack.sv
module ret_stack
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic [SP_W-1:0] sp,
  output logic [SP_W:0]   depth,
  output logic            ovf_evt,
  output logic            unf_evt
);

  localparam logic [SP_W:0] FULL = (SP_W+1)'(DEPTH);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W:0]   depth_q;
  logic [SP_W-1:0] rd_idx;

  assign rd_idx  = sp_q - SP_W'(1);
  assign dout    = mem_q[rd_idx];
  assign sp      = sp_q;
  assign depth   = depth_q;
  assign ovf_evt = push && !pop && (depth_q == FULL);
  assign unf_evt = pop && (depth_q == '0);

  // Contents are deliberately left out of reset; only the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !pop) begin
      mem_q[sp_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= '0;
      depth_q <= '0;
    end else if (pop) begin
      sp_q    <= rd_idx;
      depth_q <= (depth_q == '0) ? '0 : depth_q - (SP_W+1)'(1);
    end else if (push) begin
      sp_q    <= sp_q + SP_W'(1);
      depth_q <= (depth_q == FULL) ? FULL : depth_q + (SP_W+1)'(1);
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
module pc_stack_unit
  import pic_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adv,
  input  logic                 is_goto,
  input  logic                 is_call,
  input  logic                 is_ret,
  input  logic                 skip,
  input  logic [TGT_W-1:0]     target,
  input  logic [PC_W-TGT_W-1:0] page,
  output logic [PC_W-1:0]      pc,
  output logic                 bubble,
  output logic [SP_W-1:0]      sp,
  output logic                 stk_ovf,
  output logic                 stk_unf
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;
  logic            ovf_q;
  logic            unf_q;

  logic            run_adv;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_pc;
  logic [PC_W-1:0] ret_pc;
  logic [SP_W:0]   depth;
  logic            ovf_evt;
  logic            unf_evt;

  assign run_adv = adv && (state_q == RUN);
  assign pop     = run_adv && is_ret;
  assign push    = run_adv && !is_ret && is_call;
  assign pc_inc  = pc_q + PC_W'(1);
  assign jump_pc = {page, target};

  ret_stack u_ret_stack (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .din     (pc_inc),
    .dout    (ret_pc),
    .sp      (sp),
    .depth   (depth),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (adv) begin
      case (state_q)
        RUN: begin
          if (is_ret) begin
            pc_q    <= ret_pc;
            unf_q   <= unf_q | unf_evt;
            state_q <= SQUASH;
          end else if (is_call) begin
            pc_q    <= jump_pc;
            ovf_q   <= ovf_q | ovf_evt;
            state_q <= SQUASH;
          end else if (is_goto) begin
            pc_q    <= jump_pc;
            state_q <= SQUASH;
          end else if (skip) begin
            pc_q    <= pc_inc;
            state_q <= SQUASH;
          end else begin
            pc_q    <= pc_inc;
            state_q <= RUN;
          end
        end
        SQUASH: begin
          pc_q    <= pc_inc;
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign bubble  = (state_q == SQUASH);
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;

  logic unused_depth;
  assign unused_depth = ^depth;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  logic        clk;
  logic        reset;
  logic        adv;
  logic        is_goto;
  logic        is_call;
  logic        is_ret;
  logic        skip;
  logic [10:0] target;
  logic [1:0]  page;
  logic [12:0] pc;
  logic        bubble;
  logic [2:0]  sp;
  logic        stk_ovf;
  logic        stk_unf;

  int unsigned checks;
  int unsigned failures;

  pc_stack_unit dut (
    .clk     (clk),
    .reset   (reset),
    .adv     (adv),
    .is_goto (is_goto),
    .is_call (is_call),
    .is_ret  (is_ret),
    .skip    (skip),
    .target  (target),
    .page    (page),
    .pc      (pc),
    .bubble  (bubble),
    .sp      (sp),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic g, input logic c, input logic r, input logic s,
                      input logic [12:0] addr);
    @(negedge clk);
    is_goto = g;
    is_call = c;
    is_ret  = r;
    skip    = s;
    page    = addr[12:11];
    target  = addr[10:0];
    adv     = 1'b1;
    @(posedge clk);
    #1;
    adv     = 1'b0;
    is_goto = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    skip    = 1'b0;
  endtask

  task automatic go_run(input logic [12:0] addr);
    step(1'b1, 1'b0, 1'b0, 1'b0, addr);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    adv      = 1'b0;
    is_goto  = 1'b0;
    is_call  = 1'b0;
    is_ret   = 1'b0;
    skip     = 1'b0;
    target   = '0;
    page     = '0;

    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_ovf", 32'(stk_ovf), 32'h0);
    chk("rst_unf", 32'(stk_unf), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // 1: sequential fetch
    for (int unsigned i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
      chk("seq_pc", 32'(pc), 32'(i));
      chk("seq_bubble", 32'(bubble), 32'h0);
    end
    chk("seq_sp", 32'(sp), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_pc", 32'(pc), 32'h4);

    // 2: goto, then squashed call is ignored
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    chk("pc5", 32'(pc), 32'h5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 13'h0923);
    chk("goto_pc", 32'(pc), 32'h0923);
    chk("goto_bubble", 32'(bubble), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'h0444);
    chk("sq_pc", 32'(pc), 32'h0924);
    chk("sq_bubble", 32'(bubble), 32'h0);
    chk("sq_sp", 32'(sp), 32'h0);

    // 3: call / return
    go_run(13'h000F);
    chk("pc10", 32'(pc), 32'h0010);
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'h0200);
    chk("call_pc", 32'(pc), 32'h0200);
    chk("call_sp", 32'(sp), 32'h1);
    chk("call_bubble", 32'(bubble), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0);
    chk("ret_pc", 32'(pc), 32'h0011);
    chk("ret_sp", 32'(sp), 32'h0);
    chk("ret_ovf", 32'(stk_ovf), 32'h0);
    chk("ret_unf", 32'(stk_unf), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);

    // 4: nine nested calls wrap the stack, nine returns underflow it
    for (int unsigned i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 13'(32'h100 + i));
      chk("ncall_pc", 32'(pc), 32'h100 + i);
      step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    end
    chk("ncall_sp", 32'(sp), 32'h1);
    chk("ncall_ovf", 32'(stk_ovf), 32'h1);
    chk("ncall_unf", 32'(stk_unf), 32'h0);
    for (int unsigned k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0);
      chk("nret_pc", 32'(pc), 32'h109 - k);
      step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    end
    chk("nret_unf0", 32'(stk_unf), 32'h0);
    chk("nret_sp8", 32'(sp), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0);
    chk("unf_pc", 32'(pc), 32'h109);
    chk("unf_flag", 32'(stk_unf), 32'h1);
    chk("unf_sp", 32'(sp), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);

    // 5: skip, and goto outranks skip
    go_run(13'h003F);
    chk("pc40", 32'(pc), 32'h0040);
    step(1'b0, 1'b0, 1'b0, 1'b1, 13'h0);
    chk("skip_pc", 32'(pc), 32'h0041);
    chk("skip_bubble", 32'(bubble), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    chk("skip2_pc", 32'(pc), 32'h0042);
    chk("skip2_bubble", 32'(bubble), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 13'h0050);
    chk("gskip_pc", 32'(pc), 32'h0050);
    chk("gskip_bubble", 32'(bubble), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);

    // 6: PC wrap, call return address wrap, async reset
    go_run(13'h1FFE);
    chk("pc1fff", 32'(pc), 32'h1FFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    chk("wrap_pc", 32'(pc), 32'h0000);
    go_run(13'h1FFE);
    step(1'b0, 1'b1, 1'b0, 1'b0, 13'h0300);
    chk("wcall_pc", 32'(pc), 32'h0300);
    step(1'b0, 1'b0, 1'b0, 1'b0, 13'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 13'h0);
    chk("wret_pc", 32'(pc), 32'h0000);
    chk("pre_rst_bubble", 32'(bubble), 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_bubble", 32'(bubble), 32'h0);
    chk("arst_sp", 32'(sp), 32'h0);
    chk("arst_ovf", 32'(stk_ovf), 32'h0);
    chk("arst_unf", 32'(stk_unf), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Next-instruction-address stage that drives the program counter into instruction memory.
- Supports sequential fetch, GOTO, CALL and RETURN through an 8-level hardware return stack.
- Supports conditional skip.
- Flags the fetched instruction for squashing (bubble) after any control-flow change.
- Advances once per instruction cycle on a strobe from the phase generator; consumes decoder outputs.

Parameters:
- PC_W, 13, program counter width.
- TGT_W, 11, literal target width carried in GOTO/CALL instructions.
- DEPTH, 8, return-stack entries (power of 2).
- SP_W, 3, stack pointer width (log2 DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- adv  input  1  one-clk strobe marking the end of an instruction cycle; all state changes occur only on edges where adv=1.
- is_goto  input  1  decoded GOTO.
- is_call  input  1  decoded CALL.
- is_ret  input  1  decoded RETURN.
- skip  input  1  skip condition true for the current instruction.
- target  input  TGT_W  literal jump/call target.
- page  input  PC_W-TGT_W  upper PC bits (page select) for GOTO/CALL.
- pc  output  PC_W  current fetch address.
- bubble  output  1  current fetched instruction must execute as NOP.
- sp  output  SP_W  stack pointer (next free slot).
- stk_ovf  output  1  sticky: a push occurred at depth DEPTH.
- stk_unf  output  1  sticky: a pop occurred at depth 0.

Behaviour:
- Reset (async, reset=0): pc=0, bubble=0, sp=0, depth=0, stk_ovf=0, stk_unf=0. Stack contents are not reset. Outputs hold while reset=0 regardless of clk/adv.
- Edges with adv=0: no state change.
- FSM: two states.
  - RUN: bubble=0.
  - SQUASH: bubble=1.
  - Reset enters RUN.
- SQUASH on adv: pc<=pc+1, state<=RUN. All decode inputs are ignored; a squashed instruction never branches, calls, returns or skips.
- RUN on adv, priority ret > call > goto > skip > increment:
  - ret: pc<=stack[sp-1]; sp<=sp-1 (mod DEPTH); depth<=depth-1, saturating at 0. If depth was 0, set stk_unf; the pop still loads from the wrapped slot. state<=SQUASH.
  - call: stack[sp]<=pc+1 (mod 2^PC_W); sp<=sp+1 (mod DEPTH); depth<=min(depth+1,DEPTH). If depth was DEPTH, set stk_ovf; the oldest entry is overwritten (circular). pc<={page,target}. state<=SQUASH.
  - goto: pc<={page,target}; state<=SQUASH.
  - skip: pc<=pc+1; state<=SQUASH.
  - none: pc<=pc+1; stay in RUN.
- PC arithmetic is modulo 2^PC_W: 0x1FFF+1 = 0x0000. The return address for a call at 0x1FFF is 0x0000.
- Latency: pc, sp, bubble and flags update on the same rising edge that samples adv=1; new values are visible in the following cycle.
- stk_ovf and stk_unf are cleared only by reset.
- Reset mid-instruction-cycle (between adv strobes) aborts immediately to reset values. No partial push survives: the stack write and the sp update happen on the same edge.
- depth is internal, 0..DEPTH, width SP_W+1.

Decomposition:
- Shared package pic_pkg holds:
  - PC_W, TGT_W, DEPTH, SP_W constants.
  - RESET_VECTOR (0).
  - Enum typedef fetch_state_t {RUN, SQUASH}.
- One sub-module, ret_stack: a DEPTH x PC_W register-file LIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, sp, depth, ovf_evt, unf_evt.
  - Contents written only on push; no reset of contents.
- pc_stack_unit keeps the PC register, the FSM, the priority mux and the sticky flags.

Test Plan:
1. Reset=0, then release; 4 adv strobes with no decode → pc 0,1,2,3,4; bubble=0 throughout; sp=0.
2. At pc=5, is_goto with page=2'b01, target=0x123 → pc=0x0923, bubble=1. Next adv has is_call=1 asserted (must be ignored) → pc=0x0924, bubble=0, sp=0.
3. At pc=0x0010, is_call with target=0x200, page=0 → pc=0x0200, sp=1, bubble=1. Later is_ret → pc=0x0011, sp=0, no flags set.
4. Nine nested calls (targets 0x100..0x108) → after the 9th, sp=1 and stk_ovf=1. Nine rets: the first 8 rets restore the correct return addresses; the 9th ret sets stk_unf=1, and pc equals the value left in the wrapped slot.
5. skip asserted at pc=0x0040 → pc=0x0041, bubble=1; next adv → pc=0x0042, bubble=0. Separately, skip with is_goto both high → the goto wins.
6. At pc=0x1FFF with no decode → pc=0x0000. Assert reset=0 between adv strobes while bubble=1 → pc=0, bubble=0, sp=0, both flags 0 immediately, without waiting for a clk edge.
